// File: rtl/countdown_pkg.sv
// Shared types and constants for the four-digit BCD countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_e;

  typedef logic [3:0] bcd_t;

  // SS.CC time value, most significant digit first.
  typedef struct packed {
    bcd_t deca;
    bcd_t unit;
    bcd_t deci;
    bcd_t centi;
  } bcd_time_t;

  localparam int TICK_DIV_DEFAULT = 500000;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_NINE = 4'd9;

  localparam bcd_time_t TIME_ZERO      = 16'h0000;
  localparam bcd_time_t TIME_ONE_CENTI = 16'h0001;

  // One BCD digit plus one, 9 wrapping to 0; callers derive the carry themselves.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d == BCD_NINE) ? BCD_ZERO : d + 4'd1;
  endfunction

  function automatic logic is_bcd(input bcd_time_t t);
    return (t.deca <= BCD_NINE) && (t.unit <= BCD_NINE) &&
           (t.deci <= BCD_NINE) && (t.centi <= BCD_NINE);
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_if.sv
// Board-facing signals of the countdown timer: switch, four buttons, LEDs, alarm.
interface countdown_timer_bcd_if;

  logic       SW;
  logic       BTN_SOUTH;
  logic       BTN_NORTH;
  logic       BTN_EAST;
  logic       BTN_WEST;
  logic [7:0] LED;
  logic       ALARM;

  modport master (
    output SW, BTN_SOUTH, BTN_NORTH, BTN_EAST, BTN_WEST,
    input  LED, ALARM
  );

  modport slave (
    input  SW, BTN_SOUTH, BTN_NORTH, BTN_EAST, BTN_WEST,
    output LED, ALARM
  );

endinterface

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: synchronous load wins over decrement,
// borrow_out is combinational so four digits ripple within one cycle.
module bcd_down_digit
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  bcd_t load_val,
  input  logic borrow_in,
  output logic borrow_out,
  output bcd_t digit
);

  bcd_t digit_d;
  bcd_t digit_q;

  // Next digit: load, else borrow one (0 wraps to 9), else hold.
  always_comb begin
    // NOTE: default assignment first so every path drives digit_d and no latch is inferred.
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (borrow_in) begin
      digit_d = (digit_q == BCD_ZERO) ? BCD_NINE : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
    if (!rst_n) digit_q <= BCD_ZERO;
    else        digit_q <= digit_d;
  end

  assign borrow_out = borrow_in & (digit_q == BCD_ZERO);
  assign digit      = digit_q;

  a_digit_is_bcd: assert property (@(posedge clk) disable iff (!rst_n) digit_q <= BCD_NINE);

endmodule

// File: rtl/countdown_timer_bcd.sv
// SS.CC countdown timer: button-entered preset, 10 ms ticks, alarm at 00.00,
// two BCD digits at a time on the LEDs.
module countdown_timer_bcd
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                  CLK_50M,
  input  logic                  RST_N,
  countdown_timer_bcd_if.slave  bus
);

  localparam int               CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  state_e           state_d, state_q;
  bcd_time_t        preset_d, preset_q;
  logic [CNT_W-1:0] tick_cnt_d, tick_cnt_q;
  logic [3:0]       btn_lvl_d, btn_lvl_q;
  logic [3:0]       btn_prev_d, btn_prev_q;
  logic [7:0]       led_d, led_q;
  logic             alarm_d, alarm_q;

  logic [3:0] btn_raw;
  logic [3:0] press;
  logic       ev_north, ev_south, ev_east, ev_west;
  logic       tick;
  logic       count_load;

  bcd_time_t count;
  bcd_t      cnt_deca, cnt_unit, cnt_deci, cnt_centi;
  logic      borrow_centi, borrow_deci, borrow_unit, borrow_deca;

  // Bit order everywhere is {north, south, east, west}.
  assign btn_raw = {bus.BTN_NORTH, bus.BTN_SOUTH, bus.BTN_EAST, bus.BTN_WEST};
  assign press   = btn_lvl_q & ~btn_prev_q;

  // Fixed priority so exactly one event acts per cycle.
  assign ev_north = press[3];
  assign ev_south = press[2] & ~press[3];
  assign ev_east  = press[1] & ~(|press[3:2]);
  assign ev_west  = press[0] & ~(|press[3:1]);

  // Next state, preset, tick phase and registered outputs.
  always_comb begin
    state_d    = state_q;
    preset_d   = preset_q;
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    btn_lvl_d  = btn_raw;
    btn_prev_d = btn_lvl_q;
    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (ev_north) begin
          preset_d = TIME_ZERO;
        end else if (ev_south) begin
          if (preset_q != TIME_ZERO) state_d = RUN;
        end else if (ev_east) begin
          preset_d.unit = bcd_inc(preset_q.unit);
          if (preset_q.unit == BCD_NINE) preset_d.deca = bcd_inc(preset_q.deca);
        end else if (ev_west) begin
          preset_d.deca = bcd_inc(preset_q.deca);
        end
      end
      RUN: begin
        if (tick_cnt_q == TICK_LAST) begin
          tick_cnt_d = '0;
          tick       = 1'b1;
        end else begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
        // Expiry outranks pause so PAUSE is never entered holding 00.00.
        if (ev_north)                                  state_d = IDLE;
        else if (tick && (count == TIME_ONE_CENTI))    state_d = EXPIRED;
        else if (ev_south)                             state_d = PAUSE;
      end
      PAUSE: begin
        if (ev_north)      state_d = IDLE;
        else if (ev_south) state_d = RUN;
      end
      EXPIRED: begin
        if (|press) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Loading from preset_d keeps count equal to preset throughout IDLE.
    count_load = (state_d == IDLE);
    led_d      = bus.SW ? {count.deca, count.unit} : {count.deci, count.centi};
    alarm_d    = (state_q == EXPIRED);
  end

  // Control and output registers.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      preset_q   <= TIME_ZERO;
      tick_cnt_q <= '0;
      btn_lvl_q  <= '0;
      btn_prev_q <= '0;
      led_q      <= 8'h00;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      preset_q   <= preset_d;
      tick_cnt_q <= tick_cnt_d;
      btn_lvl_q  <= btn_lvl_d;
      btn_prev_q <= btn_prev_d;
      led_q      <= led_d;
      alarm_q    <= alarm_d;
    end
  end

  bcd_down_digit u_centi (
    .clk(CLK_50M), .rst_n(RST_N), .load(count_load), .load_val(preset_d.centi),
    .borrow_in(tick), .borrow_out(borrow_centi), .digit(cnt_centi)
  );
  bcd_down_digit u_deci (
    .clk(CLK_50M), .rst_n(RST_N), .load(count_load), .load_val(preset_d.deci),
    .borrow_in(borrow_centi), .borrow_out(borrow_deci), .digit(cnt_deci)
  );
  bcd_down_digit u_unit (
    .clk(CLK_50M), .rst_n(RST_N), .load(count_load), .load_val(preset_d.unit),
    .borrow_in(borrow_deci), .borrow_out(borrow_unit), .digit(cnt_unit)
  );
  bcd_down_digit u_deca (
    .clk(CLK_50M), .rst_n(RST_N), .load(count_load), .load_val(preset_d.deca),
    .borrow_in(borrow_unit), .borrow_out(borrow_deca), .digit(cnt_deca)
  );

  assign count     = {cnt_deca, cnt_unit, cnt_deci, cnt_centi};
  assign bus.LED   = led_q;
  assign bus.ALARM = alarm_q;

  a_preset_is_bcd: assert property (@(posedge CLK_50M) disable iff (!RST_N) is_bcd(preset_q));
  a_no_underflow:  assert property (@(posedge CLK_50M) disable iff (!RST_N) !borrow_deca);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Directed plus random bench for countdown_timer_bcd with TICK_DIV = 4.
// The reference model keeps preset as whole seconds and the run time as a
// count of RUN cycles; the displayed count is preset*100 - run_cycles/TICK_DIV.
module tb_countdown_timer_bcd;

  localparam int TD = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXPIRED = 3;

  // Button vector order: {north, south, east, west}.
  localparam logic [3:0] B_N = 4'b1000, B_S = 4'b0100, B_E = 4'b0010, B_W = 4'b0001;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw    = 1'b0;
  logic [3:0] btn   = 4'b0000;

  always #5 clk = ~clk;

  countdown_timer_bcd_if bif ();

  assign bif.SW        = sw;
  assign bif.BTN_NORTH = btn[3];
  assign bif.BTN_SOUTH = btn[2];
  assign bif.BTN_EAST  = btn[1];
  assign bif.BTN_WEST  = btn[0];

  countdown_timer_bcd #(.TICK_DIV(TD)) dut (
    .CLK_50M (clk),
    .RST_N   (rst_n),
    .bus     (bif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state.
  int         mode;
  int         preset_s;
  int         run_cyc;
  logic [3:0] m_lvl, m_prev;
  logic [7:0] exp_led;
  logic       exp_alarm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_cs();
    if (mode == M_IDLE)    return preset_s * 100;
    if (mode == M_EXPIRED) return 0;
    return preset_s * 100 - run_cyc / TD;
  endfunction

  function automatic logic [7:0] led_of(input int cs, input logic s);
    int d3, d2, d1, d0;
    d3 = cs / 1000;
    d2 = (cs / 100) % 10;
    d1 = (cs / 10) % 10;
    d0 = cs % 10;
    return s ? {d3[3:0], d2[3:0]} : {d1[3:0], d0[3:0]};
  endfunction

  task automatic model_reset();
    mode      = M_IDLE;
    preset_s  = 0;
    run_cyc   = 0;
    m_lvl     = '0;
    m_prev    = '0;
    exp_led   = 8'h00;
    exp_alarm = 1'b0;
  endtask

  // One clock: advance the model across the edge, then compare outputs.
  task automatic step();
    logic [3:0] ev;
    exp_led   = led_of(model_cs(), sw);
    exp_alarm = (mode == M_EXPIRED);
    @(posedge clk);
    cyc++;
    ev     = m_lvl & ~m_prev;
    m_prev = m_lvl;
    m_lvl  = btn;
    case (mode)
      M_IDLE: begin
        if (ev[3])      preset_s = 0;
        else if (ev[2]) begin
          if (preset_s != 0) begin
            mode    = M_RUN;
            run_cyc = 0;
          end
        end
        else if (ev[1]) preset_s = (preset_s + 1) % 100;
        else if (ev[0]) preset_s = ((preset_s / 10 + 1) % 10) * 10 + preset_s % 10;
      end
      M_RUN: begin
        run_cyc++;
        if (ev[3])                                mode = M_IDLE;
        else if (run_cyc == preset_s * 100 * TD)  mode = M_EXPIRED;
        else if (ev[2])                           mode = M_PAUSE;
      end
      M_PAUSE: begin
        if (ev[3])      mode = M_IDLE;
        else if (ev[2]) mode = M_RUN;
      end
      default: begin
        if (ev != 4'b0000) mode = M_IDLE;
      end
    endcase
    @(negedge clk);
    check("led", bif.LED, exp_led);
    check("alarm", bif.ALARM, exp_alarm);
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    btn = b;
    repeat (hold) step();
    btn = 4'b0000;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, e0, p, r, a;
    model_reset();

    // Reset state.
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", bif.LED, 8'h00);
    check("reset_alarm", bif.ALARM, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();

    // Start with a zero preset is ignored: a following EAST still edits the preset.
    press(B_S, 2);
    repeat (2) step();
    sw = 1'b1;
    press(B_E, 1);
    step();
    check("zero_start_ignored", bif.LED, 8'h01);

    // Preset entry and deca wrap.
    press(B_N, 1);
    repeat (3) press(B_E, 1);
    repeat (2) press(B_W, 1);
    repeat (2) step();
    check("preset_23", bif.LED, 8'h23);
    repeat (8) press(B_W, 1);
    repeat (2) step();
    check("preset_deca_wrap", bif.LED, 8'h03);

    // Countdown 01.00 to expiry.
    press(B_N, 1);
    press(B_E, 1);
    sw  = 1'b0;
    btn = B_S;
    step();
    step();
    btn = 4'b0000;
    step();
    n = 0;
    while (bif.ALARM !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check("expire_cycles", n, 100 * TD);
    check("expired_led", bif.LED, 8'h00);
    sw = 1'b1;
    press(B_W, 1);
    step();
    check("alarm_cleared", bif.ALARM, 1'b0);
    check("reload_preset", bif.LED, 8'h01);

    // Borrow chain from 10.00.
    press(B_N, 1);
    press(B_W, 1);
    btn = B_S;
    step();
    step();
    btn = 4'b0000;
    step();
    repeat (4) step();
    check("borrow_hi", bif.LED, 8'h09);
    sw = 1'b0;
    step();
    check("borrow_lo", bif.LED, 8'h99);
    press(B_N, 1);

    // Pause with the tick phase at 2, resume, and total RUN time to expiry.
    press(B_N, 1);
    press(B_E, 1);
    btn = B_S;
    step();
    step();
    e0  = cyc;
    btn = 4'b0000;
    repeat (4) step();
    btn = B_S;
    step();
    step();
    p   = cyc;
    btn = 4'b0000;
    repeat (50) step();
    check("paused_led", bif.LED, 8'h99);
    btn = B_S;
    step();
    step();
    r   = cyc;
    btn = 4'b0000;
    step();
    step();
    check("resume_before_tick", bif.LED, 8'h99);
    step();
    check("resume_tick_after_2", bif.LED, 8'h98);
    n = 0;
    while (bif.ALARM !== 1'b1 && n < 3000) begin
      step();
      n++;
    end
    a = cyc;
    check("pause_run_cycles", (a - 1 - e0) - (r - p), 100 * TD);

    // NORTH and SOUTH together during RUN: NORTH wins, count reloads.
    press(B_E, 1);
    sw = 1'b1;
    press(B_S, 2);
    repeat (10) step();
    press(B_N | B_S, 2);
    step();
    check("priority_reload", bif.LED, 8'h01);
    check("priority_alarm", bif.ALARM, 1'b0);

    // Asynchronous reset mid-RUN.
    sw = 1'b0;
    press(B_S, 2);
    repeat (20) step();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_led", bif.LED, 8'h00);
    check("async_reset_alarm", bif.ALARM, 1'b0);
    model_reset();
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sw    = 1'b1;
    repeat (3) step();
    check("post_reset_preset", bif.LED, 8'h00);

    // Random button traffic against the model.
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 11);
      case (sel)
        0, 1:    begin sw = ~sw; step(); end
        2, 3:    press(B_S, $urandom_range(1, 3));
        4, 5, 6: press(B_E, $urandom_range(1, 3));
        7:       press(B_N, $urandom_range(1, 3));
        8:       press(B_W, $urandom_range(1, 3));
        9:       press(4'($urandom_range(1, 15)), $urandom_range(1, 3));
        default: repeat ($urandom_range(1, 30)) step();
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
